// File: rtl/mesi_isc_agent_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mesi_isc_agent_pkg                                                   |
// | Bus command encodings and FSM state types for the MESI CPU agent.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mesi_isc_agent_pkg;

    // Main-bus commands, matching mesi_isc_define.v
    localparam logic [2:0] c_mbus_nop      = 3'd0;
    localparam logic [2:0] c_mbus_wr       = 3'd1;
    localparam logic [2:0] c_mbus_rd       = 3'd2;
    localparam logic [2:0] c_mbus_wr_broad = 3'd3;
    localparam logic [2:0] c_mbus_rd_broad = 3'd4;

    // Coherence-bus commands
    localparam logic [2:0] c_cbus_nop      = 3'd0;
    localparam logic [2:0] c_cbus_wr_snoop = 3'd1;
    localparam logic [2:0] c_cbus_rd_snoop = 3'd2;
    localparam logic [2:0] c_cbus_en_wr    = 3'd3;
    localparam logic [2:0] c_cbus_en_rd    = 3'd4;

    typedef enum logic [1:0] {
        REQ_IDLE    = 2'd0,
        REQ_BROAD   = 2'd1,
        REQ_WAIT_EN = 2'd2,
        REQ_ACCESS  = 2'd3
    } req_state_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_GAP  = 2'd3
    } snp_state_t;

endpackage
`default_nettype wire

// File: rtl/mesi_isc_snoop_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mesi_isc_snoop_resp                                                  |
// | Coherence-bus responder: snoop capture, latency count, ack and gap.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mesi_isc_snoop_resp
    import mesi_isc_agent_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int SNOOP_LAT      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
    input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
    input  logic                      en_match_i,
    output logic                      cbus_ack_o,
    output logic                      en_ack_o,
    output logic                      snoop_valid_o,
    output logic                      snoop_wr_o,
    output logic [ADDR_WIDTH-1:0]     snoop_addr_o
);

    localparam logic [3:0] c_lat = 4'(SNOOP_LAT);

    snp_state_t              r_state;
    snp_state_t              w_next;
    logic [3:0]              r_cnt;
    logic                    r_wr;
    logic                    r_is_snoop;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    w_wr_snoop;
    logic                    w_snoop_cmd;

    assign w_wr_snoop  = (cbus_cmd_i == CBUS_CMD_WIDTH'(c_cbus_wr_snoop));
    assign w_snoop_cmd = w_wr_snoop || (cbus_cmd_i == CBUS_CMD_WIDTH'(c_cbus_rd_snoop));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_snoop_cmd)
                    w_next = (c_lat == 4'd0) ? S_ACK : S_WAIT;
                else if (en_match_i)
                    w_next = S_ACK;
            end
            S_WAIT:  if (r_cnt <= 4'd1) w_next = S_ACK;
            S_ACK:   w_next = S_GAP;
            // Controller still holds the command this cycle; ignore it
            S_GAP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_wr       <= 1'b0;
            r_is_snoop <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_snoop_cmd) begin
                r_cnt      <= c_lat;
                r_wr       <= w_wr_snoop;
                r_is_snoop <= 1'b1;
                r_addr     <= cbus_addr_i;
            end else if (r_state == S_IDLE && en_match_i) begin
                r_is_snoop <= 1'b0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    assign cbus_ack_o    = (r_state == S_ACK);
    assign snoop_valid_o = cbus_ack_o && r_is_snoop;
    assign en_ack_o      = cbus_ack_o && !r_is_snoop;
    assign snoop_wr_o    = snoop_valid_o && r_wr;
    assign snoop_addr_o  = r_addr;

endmodule
`default_nettype wire

// File: rtl/mesi_isc_cpu_agent.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mesi_isc_cpu_agent                                                   |
// | Per-CPU MESI bus agent: broadcast, enable wait, access, snoop acks.  |
// | Optional watchdog output enabled by MESI_ISC_AGENT_TIMEOUT_EN.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mesi_isc_cpu_agent
    import mesi_isc_agent_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int SNOOP_LAT      = 2,
    parameter int TIMEOUT_CYC    = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid_i,
    input  logic                      req_wr_i,
    input  logic [ADDR_WIDTH-1:0]     req_addr_i,
    output logic                      req_ready_o,
    output logic                      done_o,
    output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
    output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
    input  logic                      mbus_ack_i,
    input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
    input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
    output logic                      cbus_ack_o,
    output logic                      snoop_valid_o,
    output logic                      snoop_wr_o,
    output logic [ADDR_WIDTH-1:0]     snoop_addr_o
`ifdef MESI_ISC_AGENT_TIMEOUT_EN
    ,output logic                     timeout_o
`endif
);

    req_state_t            r_state;
    req_state_t            w_next;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_done;
    logic                  w_en_match;
    logic                  w_en_ack;

    // done_o occupies one IDLE cycle in which no new request is taken
    assign req_ready_o = (r_state == REQ_IDLE) && !r_done;
    assign done_o      = r_done;

    assign w_en_match = (r_state == REQ_WAIT_EN) &&
                        (cbus_cmd_i == CBUS_CMD_WIDTH'(r_wr ? c_cbus_en_wr : c_cbus_en_rd)) &&
                        (cbus_addr_i == r_addr);

    always_comb begin
        w_next      = r_state;
        mbus_cmd_o  = MBUS_CMD_WIDTH'(c_mbus_nop);
        mbus_addr_o = '0;
        case (r_state)
            REQ_IDLE: if (req_valid_i && req_ready_o) w_next = REQ_BROAD;
            REQ_BROAD: begin
                mbus_cmd_o  = MBUS_CMD_WIDTH'(r_wr ? c_mbus_wr_broad : c_mbus_rd_broad);
                mbus_addr_o = r_addr;
                if (mbus_ack_i) w_next = REQ_WAIT_EN;
            end
            REQ_WAIT_EN: if (w_en_ack) w_next = REQ_ACCESS;
            REQ_ACCESS: begin
                mbus_cmd_o  = MBUS_CMD_WIDTH'(r_wr ? c_mbus_wr : c_mbus_rd);
                mbus_addr_o = r_addr;
                if (mbus_ack_i) w_next = REQ_IDLE;
            end
            default: w_next = REQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= REQ_IDLE;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == REQ_ACCESS) && mbus_ack_i;
            if (r_state == REQ_IDLE && req_valid_i && req_ready_o) begin
                r_wr   <= req_wr_i;
                r_addr <= req_addr_i;
            end
        end
    end

    mesi_isc_snoop_resp #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CBUS_CMD_WIDTH (CBUS_CMD_WIDTH),
        .SNOOP_LAT      (SNOOP_LAT)
    ) u_snoop_resp (
        .clk           (clk),
        .rst           (rst),
        .cbus_cmd_i    (cbus_cmd_i),
        .cbus_addr_i   (cbus_addr_i),
        .en_match_i    (w_en_match),
        .cbus_ack_o    (cbus_ack_o),
        .en_ack_o      (w_en_ack),
        .snoop_valid_o (snoop_valid_o),
        .snoop_wr_o    (snoop_wr_o),
        .snoop_addr_o  (snoop_addr_o)
    );

`ifdef MESI_ISC_AGENT_TIMEOUT_EN
    localparam int c_to_w = $clog2(TIMEOUT_CYC + 1);

    logic [c_to_w-1:0] r_to_cnt;
    logic              r_timeout;
    logic              w_counting;

    assign w_counting = (r_state != REQ_IDLE) && (w_next == r_state);
    assign timeout_o  = r_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_counting)
                r_to_cnt <= '0;
            else if (r_to_cnt != c_to_w'(TIMEOUT_CYC))
                r_to_cnt <= r_to_cnt + 1'b1;
            // Sticky; the FSM keeps waiting regardless
            if (w_counting && r_to_cnt == c_to_w'(TIMEOUT_CYC - 1))
                r_timeout <= 1'b1;
        end
    end
`else
    if (TIMEOUT_CYC > 0) begin : g_no_timeout
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mesi_isc_cpu_agent.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mesi_isc_cpu_agent                                                |
// | Vector-table bench for the MESI CPU agent, plus SNOOP_LAT=0 checks.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mesi_isc_cpu_agent;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wr, mbus_ack;
    logic [31:0] req_addr, cbus_addr;
    logic [2:0]  cbus_cmd;

    logic        req_ready, done, cbus_ack, snoop_valid, snoop_wr;
    logic [2:0]  mbus_cmd;
    logic [31:0] mbus_addr, snoop_addr;

    logic        req_ready0, done0, cbus_ack0, snoop_valid0, snoop_wr0;
    logic [2:0]  mbus_cmd0;
    logic [31:0] mbus_addr0, snoop_addr0;

    int n_cmp  = 0;
    int n_fail = 0;
    logic mon_on = 1'b0;
    logic prev_ack = 1'b0, prev_ack0 = 1'b0;

    always #5 clk = ~clk;

    mesi_isc_cpu_agent #(.SNOOP_LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_wr_i(req_wr), .req_addr_i(req_addr),
        .req_ready_o(req_ready), .done_o(done),
        .mbus_cmd_o(mbus_cmd), .mbus_addr_o(mbus_addr), .mbus_ack_i(mbus_ack),
        .cbus_cmd_i(cbus_cmd), .cbus_addr_i(cbus_addr), .cbus_ack_o(cbus_ack),
        .snoop_valid_o(snoop_valid), .snoop_wr_o(snoop_wr), .snoop_addr_o(snoop_addr)
    );

    mesi_isc_cpu_agent #(.SNOOP_LAT(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_wr_i(req_wr), .req_addr_i(req_addr),
        .req_ready_o(req_ready0), .done_o(done0),
        .mbus_cmd_o(mbus_cmd0), .mbus_addr_o(mbus_addr0), .mbus_ack_i(mbus_ack),
        .cbus_cmd_i(cbus_cmd), .cbus_addr_i(cbus_addr), .cbus_ack_o(cbus_ack0),
        .snoop_valid_o(snoop_valid0), .snoop_wr_o(snoop_wr0), .snoop_addr_o(snoop_addr0)
    );

    typedef struct {
        logic        rst, rv, rw;
        logic [31:0] ra;
        logic        mack;
        logic [2:0]  ccmd;
        logic [31:0] caddr;
        logic        e_rdy, e_done;
        logic [2:0]  e_cmd;
        logic [31:0] e_addr;
        logic        e_cack, e_sv, e_sw;
        logic [31:0] e_saddr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(logic rs, logic rv, logic rw, logic [31:0] ra, logic mack,
                               logic [2:0] ccmd, logic [31:0] caddr,
                               logic e_rdy, logic e_done, logic [2:0] e_cmd, logic [31:0] e_addr,
                               logic e_cack, logic e_sv, logic e_sw, logic [31:0] e_saddr);
        vec_t v;
        v.rst = rs; v.rv = rv; v.rw = rw; v.ra = ra; v.mack = mack;
        v.ccmd = ccmd; v.caddr = caddr;
        v.e_rdy = e_rdy; v.e_done = e_done; v.e_cmd = e_cmd; v.e_addr = e_addr;
        v.e_cack = e_cack; v.e_sv = e_sv; v.e_sw = e_sw; v.e_saddr = e_saddr;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // cbus_ack_o must never be high on two consecutive cycles
    always @(negedge clk) begin
        if (mon_on) begin
            n_cmp++;
            if ((cbus_ack && prev_ack) || (cbus_ack0 && prev_ack0)) begin
                n_fail++;
                $display("FAIL ack_consecutive: got ack=%b/%b twice in a row expected single pulses",
                         cbus_ack, cbus_ack0);
            end
        end
        prev_ack  = cbus_ack;
        prev_ack0 = cbus_ack0;
    end

    initial begin
        logic [74:0] act, exp;
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
        mbus_ack = 1'b0; cbus_cmd = 3'd0; cbus_addr = '0;

        //         rst rv rw addr   mack cmd caddr    rdy dn cmd addr  ack sv sw saddr
        // Write, zero-wait acks
        tbl.push_back(V(0,1,1,32'h1, 0,0,0,        1,0,0,32'h0, 0,0,0,32'h0));   // 0
        tbl.push_back(V(0,0,0,32'h0, 1,0,0,        0,0,3,32'h1, 0,0,0,32'h0));   // 1 BROAD
        tbl.push_back(V(0,0,0,32'h0, 0,3,32'h1,    0,0,0,32'h0, 0,0,0,32'h0));   // 2 EN_WR
        tbl.push_back(V(0,0,0,32'h0, 0,3,32'h1,    0,0,0,32'h0, 1,0,0,32'h0));   // 3 ack
        tbl.push_back(V(0,0,0,32'h0, 1,3,32'h1,    0,0,1,32'h1, 0,0,0,32'h0));   // 4 ACCESS
        tbl.push_back(V(0,1,0,32'h9, 0,0,0,        0,1,0,32'h0, 0,0,0,32'h0));   // 5 done
        tbl.push_back(V(0,0,0,32'h0, 0,0,0,        1,0,0,32'h0, 0,0,0,32'h0));   // 6
        // Read with BROAD backpressure and enable filter
        tbl.push_back(V(0,1,0,32'h7, 0,0,0,        1,0,0,32'h0, 0,0,0,32'h0));   // 7
        for (int i = 0; i < 6; i++)
            tbl.push_back(V(0,0,0,32'h0, 0,0,0,    0,0,4,32'h7, 0,0,0,32'h0));   // 8..13
        tbl.push_back(V(0,0,0,32'h0, 1,0,0,        0,0,4,32'h7, 0,0,0,32'h0));   // 14
        tbl.push_back(V(0,0,0,32'h0, 0,4,32'h8,    0,0,0,32'h0, 0,0,0,32'h0));   // 15 wrong addr
        tbl.push_back(V(0,0,0,32'h0, 0,4,32'h8,    0,0,0,32'h0, 0,0,0,32'h0));   // 16
        tbl.push_back(V(0,0,0,32'h0, 0,3,32'h7,    0,0,0,32'h0, 0,0,0,32'h0));   // 17 wrong type
        tbl.push_back(V(0,0,0,32'h0, 0,4,32'h7,    0,0,0,32'h0, 0,0,0,32'h0));   // 18 match
        tbl.push_back(V(0,0,0,32'h0, 0,4,32'h7,    0,0,0,32'h0, 1,0,0,32'h0));   // 19 ack
        tbl.push_back(V(0,0,0,32'h0, 0,4,32'h7,    0,0,2,32'h7, 0,0,0,32'h0));   // 20 ACCESS
        // WR_SNOOP during ACCESS
        tbl.push_back(V(0,0,0,32'h0, 0,1,32'h555,  0,0,2,32'h7, 0,0,0,32'h0));   // 21 sight
        tbl.push_back(V(0,0,0,32'h0, 0,1,32'h555,  0,0,2,32'h7, 0,0,0,32'h555)); // 22
        tbl.push_back(V(0,0,0,32'h0, 0,1,32'h555,  0,0,2,32'h7, 0,0,0,32'h555)); // 23
        tbl.push_back(V(0,0,0,32'h0, 1,1,32'h555,  0,0,2,32'h7, 1,1,1,32'h555)); // 24 ack
        tbl.push_back(V(0,0,0,32'h0, 0,1,32'h555,  0,1,0,32'h0, 0,0,0,32'h555)); // 25 done
        tbl.push_back(V(0,0,0,32'h0, 0,0,0,        1,0,0,32'h0, 0,0,0,32'h555)); // 26
        // Held RD_SNOOP, then back-to-back WR_SNOOP
        tbl.push_back(V(0,0,0,32'h0, 0,2,32'h10,   1,0,0,32'h0, 0,0,0,32'h555)); // 27 sight
        tbl.push_back(V(0,0,0,32'h0, 0,2,32'h10,   1,0,0,32'h0, 0,0,0,32'h10));  // 28
        tbl.push_back(V(0,0,0,32'h0, 0,2,32'h10,   1,0,0,32'h0, 0,0,0,32'h10));  // 29
        tbl.push_back(V(0,0,0,32'h0, 0,2,32'h10,   1,0,0,32'h0, 1,1,0,32'h10));  // 30 ack
        tbl.push_back(V(0,0,0,32'h0, 0,2,32'h10,   1,0,0,32'h0, 0,0,0,32'h10));  // 31 gap
        tbl.push_back(V(0,0,0,32'h0, 0,1,32'h20,   1,0,0,32'h0, 0,0,0,32'h10));  // 32 sight
        tbl.push_back(V(0,0,0,32'h0, 0,1,32'h20,   1,0,0,32'h0, 0,0,0,32'h20));  // 33
        tbl.push_back(V(0,0,0,32'h0, 0,1,32'h20,   1,0,0,32'h0, 0,0,0,32'h20));  // 34
        tbl.push_back(V(0,0,0,32'h0, 0,1,32'h20,   1,0,0,32'h0, 1,1,1,32'h20));  // 35 ack
        tbl.push_back(V(0,0,0,32'h0, 0,1,32'h20,   1,0,0,32'h0, 0,0,0,32'h20));  // 36 gap
        // Reset in WAIT_EN, then a late enable
        tbl.push_back(V(0,1,1,32'h40, 0,0,0,       1,0,0,32'h0, 0,0,0,32'h20));  // 37
        tbl.push_back(V(0,0,0,32'h0, 1,0,0,        0,0,3,32'h40,0,0,0,32'h20));  // 38 BROAD
        tbl.push_back(V(1,0,0,32'h0, 0,0,0,        0,0,0,32'h0, 0,0,0,32'h20));  // 39 rst
        tbl.push_back(V(0,0,0,32'h0, 0,3,32'h40,   1,0,0,32'h0, 0,0,0,32'h0));   // 40
        tbl.push_back(V(0,0,0,32'h0, 0,3,32'h40,   1,0,0,32'h0, 0,0,0,32'h0));   // 41
        tbl.push_back(V(0,0,0,32'h0, 0,0,0,        1,0,0,32'h0, 0,0,0,32'h0));   // 42

        repeat (2) @(posedge clk);
        mon_on = 1'b1;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            rst = tbl[i].rst; req_valid = tbl[i].rv; req_wr = tbl[i].rw; req_addr = tbl[i].ra;
            mbus_ack = tbl[i].mack; cbus_cmd = tbl[i].ccmd; cbus_addr = tbl[i].caddr;
            #1;
            act = {req_ready, done, mbus_cmd, mbus_addr, cbus_ack, snoop_valid, snoop_wr, snoop_addr};
            exp = {tbl[i].e_rdy, tbl[i].e_done, tbl[i].e_cmd, tbl[i].e_addr,
                   tbl[i].e_cack, tbl[i].e_sv, tbl[i].e_sw, tbl[i].e_saddr};
            n_cmp++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL vec%0d: got {rdy,done,cmd,addr,ack,sv,sw,saddr}=0x%0h expected 0x%0h",
                         i, act, exp);
            end
        end

        // SNOOP_LAT=0 acks the cycle after capture; SNOOP_LAT=2 three cycles after
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; mbus_ack = 1'b0;
        cbus_cmd = 3'd1; cbus_addr = 32'h99;                       // h0: sight
        #1; check("h0_ack_lat0", {31'd0, cbus_ack0}, 32'd0);
        @(posedge clk); #2;                                          // h1
        check("h1_ack_lat0",   {31'd0, cbus_ack0},    32'd1);
        check("h1_sv_lat0",    {31'd0, snoop_valid0}, 32'd1);
        check("h1_sw_lat0",    {31'd0, snoop_wr0},    32'd1);
        check("h1_saddr_lat0", snoop_addr0,           32'h99);
        check("h1_ack_lat2",   {31'd0, cbus_ack},     32'd0);
        @(posedge clk); #1; cbus_cmd = 3'd0; cbus_addr = '0; #1;    // h2: gap
        check("h2_ack_lat0",   {31'd0, cbus_ack0},    32'd0);
        check("h2_ack_lat2",   {31'd0, cbus_ack},     32'd0);
        @(posedge clk); #2;                                          // h3
        check("h3_ack_lat2",   {31'd0, cbus_ack},     32'd1);
        check("h3_sw_lat2",    {31'd0, snoop_wr},     32'd1);
        check("h3_saddr_lat2", snoop_addr,            32'h99);
        check("h3_ack_lat0",   {31'd0, cbus_ack0},    32'd0);
        // Unused command codes are never acknowledged
        @(posedge clk); #1; cbus_cmd = 3'd6; cbus_addr = 32'h5;
        repeat (4) begin
            @(posedge clk); #2;
            check("cmd6_no_ack", {30'd0, cbus_ack, cbus_ack0}, 32'd0);
        end
        cbus_cmd = 3'd0;
        @(posedge clk); #2;
        mon_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
